zero_cross_wave_gen: RTL and testbench
======================================

Name: zero_cross_wave_gen

Overview:
- Test-stimulus source for the zero-crossing measurement path: generates a periodic 14-bit offset-binary waveform (triangle, square, sawtooth) of ptos_x_ciclo samples per cycle for the DAC or loopback.
- Emits a one-sample zero_cross marker at the start of every cycle, i.e. where the waveform crosses midscale with positive slope.
- Sits between the sample-rate strobe logic and the DAC/loopback mux.

Parameters:
- DATA_W, 14, sample width (offset binary, midscale 8192).
- PTS_W, 16, width of ptos_x_ciclo and cycle counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run request (level)
- sample_en  in  1  sample strobe; the phase advances only when it is high
- ptos_x_ciclo  in  16  points per cycle; N = max(ptos_x_ciclo & ~3, 4)
- step  in  14  amplitude increment per sample (unsigned)
- wave_sel  in  2  00 triangle, 01 square, 10 sawtooth, 11 reserved (midscale)
- data  out  14  waveform sample
- data_valid  out  1  one-cycle strobe, new sample on data
- zero_cross  out  1  one-cycle pulse with the n=0 sample of each cycle
- busy  out  1  high in RUN or DRAIN
- cycle_count  out  16  cycles emitted since leaving IDLE; wraps at 65535 to 0

Behaviour:
- Reset values (async, immediate, also mid-cycle): data=8192, data_valid=0, zero_cross=0, busy=0, cycle_count=0, state=IDLE, n=0.
- States:
  - IDLE -> RUN on (enable and sample_en). On that transition: latch N, step, wave_sel; reset cycle_count to 0.
  - RUN -> DRAIN when enable is low at a sample_en.
  - DRAIN -> RUN if enable is high again at any sample_en. No gap and no phase reset.
  - DRAIN -> IDLE at the sample_en where n would wrap to 0. No n=0 sample is emitted; data returns to 8192.
- Phase index n runs 0..N-1 and advances by 1 per sample_en in RUN/DRAIN, wrapping N-1 -> 0.
- At every wrap to n=0, N, step and wave_sel are re-latched. Changes mid-cycle take effect only at the next cycle start.
- Latency: sample n appears on data with data_valid=1 exactly 1 clk after its sample_en. Outputs are registered; data holds its value between strobes.
- zero_cross=1 together with data_valid for every n=0 sample. cycle_count increments in the same cycle and equals 1 after the first zero_cross.
- Let Q=N/4. Signed offset o(n), computed at full width (≥30 bits signed, no overflow), then clamped to [-8191, +8191]:
  - triangle: o = step*n for n<Q; step*(2Q-n) for Q≤n<3Q; step*(n-4Q) for n≥3Q.
  - square: o = +min(step*Q, 8191) for n<2Q; -min(step*Q, 8191) otherwise.
  - sawtooth: o = step*n for n<2Q; step*(n-4Q) otherwise.
  - reserved: o = 0.
- data = 8192 + o. Range is 1..16383, with no wrap-around ever.
- step=0 gives constant 8192; zero_cross and cycle_count still operate.
- ptos_x_ciclo values 0..7 all give N=4.
- sample_en low for any number of clocks freezes all state; data_valid stays 0.
- enable falling and rising in the same clk window without a sample_en has no effect.

Decomposition:
- Package zcw_pkg holds: DATA_W, MID=8192, MAX_OFS=8191, the WAVE_TRI/WAVE_SQR/WAVE_SAW/WAVE_RSV codes, and the state encoding IDLE/RUN/DRAIN.
- One sub-module, zcw_shaper: combinational; inputs n, Q, step, wave_sel; output clamped 14-bit data. The top holds the FSM, phase counter, config latches and output registers.

Test Plan:
- Triangle, N=16, step=100, sample_en every clk: data n=0..15 = 8192,8292,8392,8492,8592,8492,8392,8292,8192,8092,7992,7892,7792,7892,7992,8092. zero_cross only at n=0. cycle_count=1,2,3 over 3 cycles.
- Square, N=16, step=100: n0-7 = 8592, n8-15 = 7792. Sawtooth, same settings: n7 = 8892, n8 = 7392.
- Saturation: triangle, N=16, step=3000: values 8192,11192,14192,16383(clamped),16383,…,min 1. Never outside 1..16383.
- enable dropped at n=5 (N=16): samples continue through n=15, then data=8192, busy=0, no extra zero_cross. Separately, enable re-asserted at n=10 during DRAIN: n=11 follows with no gap.
- Config change ptos_x_ciclo 16 -> 8 at n=6: the remaining 9 samples use N=16; the next cycle has 8 samples. ptos_x_ciclo=3 gives 4-sample cycles.
- sample_en every 3rd clk: data_valid pulses align, 1 clk after each strobe. Then assert reset_n=0 at n=9: outputs immediately at reset values; after release, a restart begins at n=0 with zero_cross.

Source files
------------

// File: rtl/zcw_pkg.sv
// Shared widths, codes and state encoding for the zero-crossing waveform generator.
package zcw_pkg;

    localparam int DATA_W  = 14;
    localparam int PTS_W   = 16;
    localparam int MID     = 8192;
    localparam int MAX_OFS = 8191;

    typedef enum logic [1:0] {
        WAVE_TRI = 2'b00,
        WAVE_SQR = 2'b01,
        WAVE_SAW = 2'b10,
        WAVE_RSV = 2'b11
    } wave_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10
    } state_t;

    // Cycle length: multiple of four, never below four.
    function automatic logic [PTS_W-1:0] pts_to_len(input logic [PTS_W-1:0] pts);
        logic [PTS_W-1:0] m;
        m = {pts[PTS_W-1:2], 2'b00};
        return (m < PTS_W'(4)) ? PTS_W'(4) : m;
    endfunction

endpackage

// File: rtl/zero_cross_wave_gen_if.sv
// Control and sample bus between the strobe logic, the generator and the DAC mux.
interface zero_cross_wave_gen_if;
    import zcw_pkg::*;

    logic              enable;
    logic              sample_en;
    logic [PTS_W-1:0]  ptos_x_ciclo;
    logic [DATA_W-1:0] step;
    logic [1:0]        wave_sel;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              zero_cross;
    logic              busy;
    logic [PTS_W-1:0]  cycle_count;

    modport master (
        output enable, sample_en, ptos_x_ciclo, step, wave_sel,
        input  data, data_valid, zero_cross, busy, cycle_count
    );

    modport slave (
        input  enable, sample_en, ptos_x_ciclo, step, wave_sel,
        output data, data_valid, zero_cross, busy, cycle_count
    );

endinterface

// File: rtl/zcw_shaper.sv
// Maps phase index and cycle quarter to a clamped offset-binary sample.
module zcw_shaper
    import zcw_pkg::*;
(
    input  logic [PTS_W-1:0]  n_i,
    input  logic [PTS_W-1:0]  q_i,
    input  logic [DATA_W-1:0] step_i,
    input  wave_t             wave_i,
    output logic [DATA_W-1:0] data_o
);

    // Wide enough that step*N never overflows before clamping.
    localparam int OW = 34;
    localparam logic signed [OW-1:0] MAX_S = OW'(MAX_OFS);
    localparam logic signed [OW-1:0] MID_S = OW'(MID);

    logic signed [OW-1:0] n_s, q_s, q2_s, q3_s, q4_s, step_s;
    logic signed [OW-1:0] amp, ofs, ofs_c;

    always_comb begin
        n_s    = $signed({{(OW-PTS_W){1'b0}}, n_i});
        q_s    = $signed({{(OW-PTS_W){1'b0}}, q_i});
        step_s = $signed({{(OW-DATA_W){1'b0}}, step_i});
        q2_s   = q_s + q_s;
        q3_s   = q2_s + q_s;
        q4_s   = q2_s + q2_s;
        amp    = step_s * q_s;
        if (amp > MAX_S) begin
            amp = MAX_S;
        end
        ofs = '0;
        unique case (wave_i)
            WAVE_TRI: begin
                if (n_s < q_s)       ofs = step_s * n_s;
                else if (n_s < q3_s) ofs = step_s * (q2_s - n_s);
                else                 ofs = step_s * (n_s - q4_s);
            end
            WAVE_SQR: ofs = (n_s < q2_s) ? amp : -amp;
            WAVE_SAW: ofs = (n_s < q2_s) ? step_s * n_s : step_s * (n_s - q4_s);
            default:  ofs = '0;
        endcase
        if (ofs > MAX_S)       ofs_c = MAX_S;
        else if (ofs < -MAX_S) ofs_c = -MAX_S;
        else                   ofs_c = ofs;
        data_o = DATA_W'(MID_S + ofs_c);
    end

endmodule

// File: rtl/zero_cross_wave_gen.sv
// Periodic test waveform source with a positive-slope zero-crossing marker per cycle.
// state | meaning
// IDLE  | output parked at midscale, waiting for enable at a strobe
// RUN   | emitting samples, rolls into the next cycle
// DRAIN | enable dropped; finish the current cycle, then park
module zero_cross_wave_gen
    import zcw_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    zero_cross_wave_gen_if.slave bus
);

    state_t            state_q, state_d;
    wave_t             wave_q, wave_d;
    logic [PTS_W-1:0]  n_q, n_d, len_q, len_d, cnt_q, cnt_d;
    logic [DATA_W-1:0] step_q, step_d, data_q, data_d, shp_data;
    logic              valid_q, valid_d, zc_q, zc_d;
    logic              wrap, load, park;

    assign wrap = (n_q == len_q - PTS_W'(1));

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        zc_d    = 1'b0;
        load    = 1'b0;
        park    = 1'b0;
        if (bus.sample_en) begin
            unique case (state_q)
                IDLE: begin
                    if (bus.enable) begin
                        state_d = RUN;
                        n_d     = '0;
                        cnt_d   = PTS_W'(1);
                        load    = 1'b1;
                        valid_d = 1'b1;
                        zc_d    = 1'b1;
                    end
                end
                RUN, DRAIN: begin
                    // Enable is only consulted at the cycle boundary to decide whether to stop.
                    if (wrap && !bus.enable) begin
                        state_d = IDLE;
                        n_d     = '0;
                        park    = 1'b1;
                    end else begin
                        state_d = bus.enable ? RUN : DRAIN;
                        valid_d = 1'b1;
                        if (wrap) begin
                            n_d   = '0;
                            cnt_d = cnt_q + PTS_W'(1);
                            load  = 1'b1;
                            zc_d  = 1'b1;
                        end else begin
                            n_d = n_q + PTS_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    n_d     = '0;
                    park    = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        len_d  = len_q;
        step_d = step_q;
        wave_d = wave_q;
        if (load) begin
            len_d  = pts_to_len(bus.ptos_x_ciclo);
            step_d = bus.step;
            wave_d = wave_t'(bus.wave_sel);
        end
    end

    zcw_shaper u_shaper (
        .n_i    (n_d),
        .q_i    ({2'b00, len_d[PTS_W-1:2]}),
        .step_i (step_d),
        .wave_i (wave_d),
        .data_o (shp_data)
    );

    always_comb begin
        data_d = data_q;
        if (valid_d)   data_d = shp_data;
        else if (park) data_d = DATA_W'(MID);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            len_q   <= PTS_W'(4);
            step_q  <= '0;
            wave_q  <= WAVE_TRI;
            cnt_q   <= '0;
            data_q  <= DATA_W'(MID);
            valid_q <= 1'b0;
            zc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            len_q   <= len_d;
            step_q  <= step_d;
            wave_q  <= wave_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            zc_q    <= zc_d;
        end
    end

    assign bus.data        = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.zero_cross  = zc_q;
    assign bus.busy        = (state_q != IDLE);
    assign bus.cycle_count = cnt_q;

endmodule

// File: tb/tb_zero_cross_wave_gen.sv
// Bench for zero_cross_wave_gen: vector table, corner sequences and a random run against a cycle-level model.
module tb_zero_cross_wave_gen;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    zero_cross_wave_gen_if bus();
    zero_cross_wave_gen dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    // Reference model: a cycle runs to completion; at each boundary it continues only if enable is high.
    bit m_on;
    int m_n, m_len, m_step, m_wave;
    int e_data, e_cnt;
    bit e_valid, e_zc;

    typedef struct {
        int wave;
        int step;
        int pts;
        int n;
        int exp;
    } vec_t;
    vec_t vt[$];

    function automatic int eff_len(int p);
        int m;
        m = p - (p % 4);
        return (m < 4) ? 4 : m;
    endfunction

    function automatic int ref_sample(int n, int len, int st, int w);
        longint q, o, a, s;
        q = len / 4;
        s = st;
        case (w)
            0: o = (n < q) ? s * n : (n < 3 * q) ? s * (2 * q - n) : s * (n - 4 * q);
            1: begin
                a = s * q;
                if (a > 8191) a = 8191;
                o = (n < 2 * q) ? a : -a;
            end
            2: o = (n < 2 * q) ? s * n : s * (n - 4 * q);
            default: o = 0;
        endcase
        if (o > 8191) o = 8191;
        if (o < -8191) o = -8191;
        return int'(8192 + o);
    endfunction

    task automatic model_reset();
        m_on = 0; m_n = 0; m_len = 4; m_step = 0; m_wave = 0;
        e_data = 8192; e_cnt = 0; e_valid = 0; e_zc = 0;
    endtask

    task automatic model_latch();
        m_len  = eff_len(int'(bus.ptos_x_ciclo));
        m_step = int'(bus.step);
        m_wave = int'(bus.wave_sel);
    endtask

    task automatic model_tick();
        e_valid = 0;
        e_zc = 0;
        if (bus.sample_en) begin
            if (!m_on) begin
                if (bus.enable) begin
                    m_on = 1; m_n = 0; model_latch();
                    e_cnt = 1; e_valid = 1; e_zc = 1;
                    e_data = ref_sample(m_n, m_len, m_step, m_wave);
                end
            end else if (m_n == m_len - 1) begin
                if (!bus.enable) begin
                    m_on = 0; m_n = 0; e_data = 8192;
                end else begin
                    m_n = 0; model_latch();
                    e_cnt = (e_cnt + 1) % 65536; e_valid = 1; e_zc = 1;
                    e_data = ref_sample(m_n, m_len, m_step, m_wave);
                end
            end else begin
                m_n = m_n + 1; e_valid = 1;
                e_data = ref_sample(m_n, m_len, m_step, m_wave);
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".data"},  int'(bus.data), e_data);
        check({tag, ".valid"}, int'(bus.data_valid), int'(e_valid));
        check({tag, ".zc"},    int'(bus.zero_cross), int'(e_zc));
        check({tag, ".busy"},  int'(bus.busy), int'(m_on));
        check({tag, ".cnt"},   int'(bus.cycle_count), e_cnt);
    endtask

    task automatic tick(input bit en, input bit se);
        bus.enable = en;
        bus.sample_en = se;
        @(posedge clk);
        model_tick();
        #1;
        compare_all("tick");
    endtask

    task automatic set_cfg(input int pts, input int st, input int w);
        bus.ptos_x_ciclo = 16'(pts);
        bus.step = 14'(st);
        bus.wave_sel = 2'(w);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all("rst");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int tri_exp[16];
        int lo, hi, zc_seen;
        tri_exp = '{8192, 8292, 8392, 8492, 8592, 8492, 8392, 8292,
                    8192, 8092, 7992, 7892, 7792, 7892, 7992, 8092};
        bus.enable = 0; bus.sample_en = 0;
        set_cfg(16, 100, 0);
        model_reset();
        apply_reset();

        // Vector table: {wave, step, pts, n, expected data}
        for (int i = 0; i < 16; i++) vt.push_back('{0, 100, 16, i, tri_exp[i]});
        vt.push_back('{1, 100, 16, 0, 8592});
        vt.push_back('{1, 100, 16, 7, 8592});
        vt.push_back('{1, 100, 16, 8, 7792});
        vt.push_back('{1, 100, 16, 15, 7792});
        vt.push_back('{2, 100, 16, 7, 8892});
        vt.push_back('{2, 100, 16, 8, 7392});
        vt.push_back('{0, 3000, 16, 2, 14192});
        vt.push_back('{0, 3000, 16, 3, 16383});
        vt.push_back('{0, 3000, 16, 12, 1});
        vt.push_back('{3, 500, 16, 5, 8192});
        vt.push_back('{0, 0, 16, 4, 8192});
        vt.push_back('{0, 100, 3, 1, 8292});
        vt.push_back('{0, 100, 3, 3, 8092});
        vt.push_back('{1, 5000, 16, 1, 16383});
        foreach (vt[k]) begin
            apply_reset();
            set_cfg(vt[k].pts, vt[k].step, vt[k].wave);
            for (int j = 0; j <= vt[k].n; j++) tick(1, 1);
            check("vec.data", int'(bus.data), vt[k].exp);
            check("vec.zc", int'(bus.zero_cross), (vt[k].n == 0) ? 1 : 0);
        end

        // Three triangle cycles: zero_cross only at n=0, cycle_count 1,2,3
        apply_reset();
        set_cfg(16, 100, 0);
        for (int i = 0; i < 48; i++) begin
            tick(1, 1);
            check("tri3.data", int'(bus.data), tri_exp[i % 16]);
            check("tri3.zc", int'(bus.zero_cross), (i % 16 == 0) ? 1 : 0);
            check("tri3.cnt", int'(bus.cycle_count), i / 16 + 1);
        end

        // Saturation stays inside 1..16383
        apply_reset();
        set_cfg(16, 3000, 0);
        lo = 16383; hi = 1;
        for (int i = 0; i < 16; i++) begin
            tick(1, 1);
            if (int'(bus.data) < lo) lo = int'(bus.data);
            if (int'(bus.data) > hi) hi = int'(bus.data);
        end
        check("sat.min", lo, 1);
        check("sat.max", hi, 16383);

        // Enable dropped at n=5: cycle finishes, then park
        apply_reset();
        set_cfg(16, 100, 0);
        for (int i = 0; i < 5; i++) tick(1, 1);
        for (int i = 5; i < 16; i++) begin
            tick(0, 1);
            check("drain.valid", int'(bus.data_valid), 1);
            check("drain.data", int'(bus.data), tri_exp[i]);
        end
        tick(0, 1);
        check("drain.park_data", int'(bus.data), 8192);
        check("drain.park_busy", int'(bus.busy), 0);
        check("drain.park_zc", int'(bus.zero_cross), 0);
        check("drain.park_valid", int'(bus.data_valid), 0);
        tick(0, 1);
        check("drain.idle_busy", int'(bus.busy), 0);

        // Enable back during drain at n=10: no gap, continues into next cycle
        apply_reset();
        for (int i = 0; i < 5; i++) tick(1, 1);
        for (int i = 5; i < 10; i++) tick(0, 1);
        check("redo.busy_drain", int'(bus.busy), 1);
        tick(1, 1);
        check("redo.n10", int'(bus.data), tri_exp[10]);
        tick(1, 1);
        check("redo.n11", int'(bus.data), tri_exp[11]);
        for (int i = 12; i < 16; i++) tick(1, 1);
        tick(1, 1);
        check("redo.wrap_zc", int'(bus.zero_cross), 1);
        check("redo.wrap_cnt", int'(bus.cycle_count), 2);

        // Length change mid-cycle applies at the next boundary
        apply_reset();
        set_cfg(16, 100, 0);
        for (int i = 0; i < 7; i++) tick(1, 1);
        set_cfg(8, 100, 0);
        zc_seen = 0;
        for (int i = 7; i < 16; i++) begin
            tick(1, 1);
            zc_seen += int'(bus.zero_cross);
        end
        check("cfg.old_tail_zc", zc_seen, 0);
        check("cfg.old_n15", int'(bus.data), 8092);
        tick(1, 1);
        check("cfg.new_start", int'(bus.zero_cross), 1);
        tick(1, 1);
        tick(1, 1);
        check("cfg.new_n2", int'(bus.data), 8392);
        for (int i = 3; i < 8; i++) tick(1, 1);
        check("cfg.new_n7", int'(bus.data), 8092);
        tick(1, 1);
        check("cfg.new_wrap", int'(bus.zero_cross), 1);
        set_cfg(3, 100, 0);
        for (int i = 1; i < 8; i++) tick(1, 1);
        tick(1, 1);
        check("cfg.len4_wrap", int'(bus.zero_cross), 1);

        // Strobe every third clock, then asynchronous reset at n=9
        apply_reset();
        set_cfg(16, 100, 0);
        for (int i = 0; i < 30; i++) begin
            tick(1, (i % 3) == 0);
            check("strobe3.valid", int'(bus.data_valid), ((i % 3) == 0) ? 1 : 0);
        end
        check("strobe3.n9", int'(bus.data), tri_exp[9]);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("arst.data", int'(bus.data), 8192);
        check("arst.busy", int'(bus.busy), 0);
        check("arst.cnt", int'(bus.cycle_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        tick(1, 1);
        check("arst.restart_zc", int'(bus.zero_cross), 1);
        check("arst.restart_data", int'(bus.data), 8192);

        // Random run against the model
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 3))
                    0: bus.ptos_x_ciclo = 16'($urandom_range(0, 7));
                    1: bus.ptos_x_ciclo = 16'(4 * $urandom_range(2, 8));
                    2: bus.ptos_x_ciclo = 16'($urandom_range(0, 40));
                    default: bus.ptos_x_ciclo = 16'($urandom_range(0, 24));
                endcase
                bus.step = ($urandom_range(0, 3) == 0) ? 14'($urandom_range(0, 16383))
                                                      : 14'($urandom_range(0, 1200));
                bus.wave_sel = 2'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 599) == 0) apply_reset();
            tick($urandom_range(0, 9) < 8, $urandom_range(0, 2) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
